// File: rtl/processor_pkg.sv
// Shared processor definitions: the loader state encoding, the stream byte
// width, and the word/address width defaults used by the processor top.
package processor_pkg;

    localparam int byte_width      = 8;
    localparam int reg_width_dflt  = 12;
    localparam int im_width_dflt   = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LO,
        HI,
        WRITE,
        FINISH,
        ERROR
    } loader_state_t;

    // Bits of a stream byte above position keep-1. These must be zero in a
    // well-formed header or high byte. The mask is zero when keep is 8.
    function automatic logic [byte_width-1:0] upper_mask(input int keep);
        return {byte_width{1'b1}} << keep;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface program_loader_if
    import processor_pkg::*;
#(
    parameter int reg_width = reg_width_dflt,
    parameter int Im_width  = im_width_dflt
) ();

    logic [byte_width-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [Im_width-1:0]   im_address;
    logic [reg_width-1:0]  im_data;
    logic                  im_wren;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output im_address,
        output im_data,
        output im_wren
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  im_address,
        input  im_data,
        input  im_wren
    );

endinterface

// File: rtl/loader_word_assembler.sv
// Builds one instruction word from a low byte and a high byte, and flags a
// high byte whose padding bits above the word width are nonzero.
module loader_word_assembler
    import processor_pkg::*;
#(
    parameter int reg_width = reg_width_dflt
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [byte_width-1:0] byte_in,
    input  logic                  lo_we,
    input  logic                  hi_we,
    output logic [reg_width-1:0]  word,
    output logic                  pad_err
);

    localparam logic [byte_width-1:0] pad_mask = upper_mask(reg_width - byte_width);

    logic [byte_width-1:0] lo_q;
    logic [reg_width-1:0]  word_q;

    assign pad_err = |(byte_in & pad_mask);
    assign word    = word_q;

    // The assembled word only changes on a clean high byte. It then holds as
    // the memory write data until the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q   <= '0;
            word_q <= '0;
        end else begin
            if (lo_we)
                lo_q <= byte_in;
            if (hi_we && !pad_err)
                word_q <= reg_width'({byte_in, lo_q});
        end
    end

endmodule

// File: rtl/program_loader.sv
// Fills instruction memory from a length-prefixed byte stream while holding
// the CPU in reset, then pulses start once the whole image is written.
module program_loader
    import processor_pkg::*;
#(
    parameter int reg_width = reg_width_dflt,
    parameter int Im_width  = im_width_dflt
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    program_loader_if.master  bus,
    output logic              cpu_hold,
    output logic              start,
    output logic              done,
    output logic              error
);

    localparam logic [byte_width-1:0] hdr_mask = upper_mask(Im_width);

    loader_state_t       state;
    logic [Im_width-1:0] count;
    logic [Im_width-1:0] addr;
    logic [Im_width-1:0] im_address_q;
    logic                rx_ready_q;
    logic                im_wren_q;
    logic                xfer;
    logic                hdr_err;
    logic                pad_err;

    assign xfer    = bus.rx_valid && rx_ready_q;
    assign hdr_err = |(bus.rx_data & hdr_mask);

    assign bus.rx_ready   = rx_ready_q;
    assign bus.im_address = im_address_q;
    assign bus.im_wren    = im_wren_q;

    loader_word_assembler #(
        .reg_width (reg_width)
    ) u_asm (
        .clk     (clk),
        .reset   (reset),
        .byte_in (bus.rx_data),
        .lo_we   (xfer && state == LO),
        .hi_we   (xfer && state == HI),
        .word    (bus.im_data),
        .pad_err (pad_err)
    );

    // NOTE: all state and registered outputs use non-blocking assignment so
    // every branch sees the pre-edge values, whatever order they are written in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            addr         <= '0;
            im_address_q <= '0;
            rx_ready_q   <= 1'b0;
            im_wren_q    <= 1'b0;
            cpu_hold     <= 1'b0;
            start        <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // Strobes default low so each is high for exactly one cycle.
            im_wren_q <= 1'b0;
            start     <= 1'b0;
            unique case (state)
                IDLE: if (load_req) begin
                    state      <= LEN;
                    rx_ready_q <= 1'b1;
                    cpu_hold   <= 1'b1;
                    done       <= 1'b0;
                    error      <= 1'b0;
                end
                LEN: if (xfer) begin
                    if (hdr_err) begin
                        state      <= ERROR;
                        rx_ready_q <= 1'b0;
                        error      <= 1'b1;
                    end else begin
                        count <= bus.rx_data[Im_width-1:0];
                        addr  <= '0;
                        state <= LO;
                    end
                end
                LO: if (xfer) state <= HI;
                HI: if (xfer) begin
                    rx_ready_q <= 1'b0;
                    if (pad_err) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end else begin
                        state        <= WRITE;
                        im_wren_q    <= 1'b1;
                        im_address_q <= addr;
                    end
                end
                // Compare before incrementing, so a full image stops at the
                // top address without wrapping.
                WRITE: if (addr == count) begin
                    state    <= FINISH;
                    cpu_hold <= 1'b0;
                    start    <= 1'b1;
                    done     <= 1'b1;
                end else begin
                    addr       <= addr + 1'b1;
                    state      <= LO;
                    rx_ready_q <= 1'b1;
                end
                FINISH: state <= IDLE;
                ERROR: if (load_req) begin
                    state      <= LEN;
                    rx_ready_q <= 1'b1;
                    error      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: stimulus queues the expected memory
// writes, a monitor pops and compares them whenever im_wren is high.
module tb_program_loader;
    import processor_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_req = 1'b0;
    logic cpu_hold, start, done, error;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    logic start_prev = 1'b0;
    wr_t exp_q[$];

    program_loader_if #(.reg_width(12), .Im_width(8)) bus ();

    program_loader #(.reg_width(12), .Im_width(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .load_req (load_req),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .start    (start),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.im_wren) begin
                check("ready_low_in_write", bus.rx_ready, 1'b0);
                check("hold_during_write", cpu_hold, 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", bus.im_address, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", bus.im_address, e.addr);
                    check("write_data", bus.im_data, e.data);
                end
            end
            if (start) begin
                start_cnt++;
                check("start_one_cycle", start_prev, 1'b0);
                check("hold_low_with_start", cpu_hold, 1'b0);
            end
            start_prev <= start;
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [11:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); ok = bus.rx_ready;
            @(posedge clk); #1;
            if (ok) return;
        end
        check("send_timeout", 0, 1);
    endtask

    // Offers the byte only every other cycle, with junk in the gaps.
    task automatic send_gappy(input logic [7:0] b);
        logic ok;
        for (int i = 0; i < 50; i++) begin
            bus.rx_data  = b;
            bus.rx_valid = 1'b1;
            @(negedge clk); ok = bus.rx_ready;
            @(posedge clk); #1;
            bus.rx_data  = 8'hFF;
            bus.rx_valid = 1'b0;
            if (ok) return;
            @(posedge clk); #1;
        end
        check("gappy_timeout", 0, 1);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (start) begin
                @(posedge clk); #1;
                return;
            end
        end
        check("start_timeout", 0, 1);
    endtask

    initial begin
        int s0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", {bus.rx_ready, bus.im_wren, cpu_hold, start, done, error}, 6'b0);
        check("rst_addr", bus.im_address, 8'h00);
        check("rst_data", bus.im_data, 12'h000);
        @(posedge clk); #1;

        // Reset asserted mid-HI with a byte on offer.
        pulse_load();
        send_byte(8'h00);
        send_byte(8'h11);
        bus.rx_data = 8'h05;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midhi_state", dut.state, IDLE);
        check("midhi_outputs", {bus.rx_ready, bus.im_wren, cpu_hold, start, done, error}, 6'b0);
        check("midhi_addr_data", {bus.im_address, bus.im_data}, 20'h0);
        repeat (6) @(negedge clk);
        check("midhi_no_start", start_cnt, 0);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;

        // Two-word image with the exact latency of wren and start.
        pulse_load();
        push_wr(8'h00, 12'hA34);
        push_wr(8'h01, 12'hBCD);
        send_byte(8'h01);
        send_byte(8'h34); send_byte(8'h0A);
        send_byte(8'hCD); send_byte(8'h0B);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("lat_wren", bus.im_wren, 1'b1);
        check("lat_hold_in_write", cpu_hold, 1'b1);
        @(negedge clk);
        check("lat_start", start, 1'b1);
        check("lat_done", done, 1'b1);
        @(negedge clk);
        check("start_dropped", start, 1'b0);
        check("done_sticky", done, 1'b1);
        check("hold_released", cpu_hold, 1'b0);
        check("two_word_starts", start_cnt, 1);
        @(posedge clk); #1;

        // Full 256-word image: must end at address 0xFF without wrapping.
        s0 = start_cnt;
        pulse_load();
        send_byte(8'hFF);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo, hi;
            lo = 8'(i);
            hi = {4'h0, lo[7:4]};
            push_wr(lo, {hi[3:0], lo});
            send_byte(lo);
            send_byte(hi);
        end
        bus.rx_valid = 1'b0;
        wait_start();
        repeat (4) @(posedge clk); #1;
        check("full_last_addr", bus.im_address, 8'hFF);
        check("full_one_start", start_cnt - s0, 1);
        check("full_done", done, 1'b1);

        // Nonzero padding in a high byte aborts without a write.
        pulse_load();
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h25);
        bus.rx_data = 8'h00;
        @(negedge clk);
        check("err_flags", {error, cpu_hold, bus.rx_ready, bus.im_wren, done}, 5'b11000);
        repeat (4) @(negedge clk);
        check("err_stays", {error, cpu_hold, bus.rx_ready}, 3'b110);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        pulse_load();
        @(negedge clk);
        check("err_cleared", {error, bus.rx_ready}, 2'b01);
        @(posedge clk); #1;
        s0 = start_cnt;
        push_wr(8'h00, 12'h577);
        send_byte(8'h00);
        send_byte(8'h77); send_byte(8'h05);
        bus.rx_valid = 1'b0;
        wait_start();
        check("recover_start", start_cnt - s0, 1);
        check("recover_flags", {done, error}, 2'b10);

        // Gappy rx_valid and a load_req issued while in LO.
        s0 = start_cnt;
        pulse_load();
        push_wr(8'h00, 12'h312);
        push_wr(8'h01, 12'h456);
        send_byte(8'h01);
        bus.rx_valid = 1'b0;
        pulse_load();
        send_gappy(8'h12); send_gappy(8'h03);
        send_gappy(8'h56); send_gappy(8'h04);
        wait_start();
        check("gappy_start", start_cnt - s0, 1);

        // Back-to-back bytes: the byte waiting through WRITE must not be lost.
        s0 = start_cnt;
        pulse_load();
        push_wr(8'h00, 12'h101);
        push_wr(8'h01, 12'hF02);
        push_wr(8'h02, 12'h0FF);
        send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h0F);
        send_byte(8'hFF); send_byte(8'h00);
        bus.rx_valid = 1'b0;
        wait_start();
        check("b2b_start", start_cnt - s0, 1);

        repeat (3) @(posedge clk);
        check("pending_writes", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory interface. The processor only reads Ins_Memory. This block fills it from a byte stream (valid/ready) before execution.
- Holds the processor in reset while loading. Pulses start when the image is fully written.
- Sits between a byte source (host link) and the Ins_Memory write port (address/data/wren). Its memory outputs are muxed with the CPU's AR path while cpu_hold is high.

Parameters:
- reg_width, 12, instruction word width; must be ≤ 16.
- Im_width, 8, instruction-memory address width; legal range 1..8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_req  in  1  single-cycle request to begin a load; honoured only in IDLE or ERROR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- im_address  out  Im_width  instruction-memory write address
- im_data  out  reg_width  instruction-memory write data
- im_wren  out  1  instruction-memory write strobe
- cpu_hold  out  1  keeps processor in reset while high
- start  out  1  one-cycle pulse to the control unit after a successful load
- done  out  1  sticky: last load completed successfully
- error  out  1  sticky: last load aborted on a format error

Behaviour:
- Reset: state IDLE. All outputs 0: rx_ready, im_address, im_data, im_wren, cpu_hold, start, done, error. Internal count and address registers also 0.
- Byte transfer occurs only when rx_valid && rx_ready are high on the same rising clk edge. rx_data is ignored otherwise.
- Image format:
  - Header byte H: image holds H[Im_width-1:0]+1 words (1..2^Im_width).
  - Then per word: low byte = word[7:0]; high byte = word[reg_width-1:8] in its low (reg_width-8) bits.
- States and transitions:
  - IDLE: rx_ready=0, cpu_hold=0. load_req → LEN; cpu_hold=1 from the next cycle; done and error cleared.
  - LEN: rx_ready=1. On transfer:
    - If header bits above Im_width-1 are nonzero → ERROR.
    - Otherwise count ← H[Im_width-1:0], addr ← 0, → LO.
  - LO: rx_ready=1. On transfer: low byte latched, → HI.
  - HI: rx_ready=1. On transfer:
    - If bits [7:reg_width-8] are nonzero → ERROR; no write occurs.
    - Otherwise im_data ← assembled word, → WRITE.
  - WRITE: rx_ready=0, im_wren=1 for exactly one cycle, im_address=addr.
    - If addr==count → FINISH.
    - Otherwise addr ← addr+1, → LO.
  - FINISH (one cycle): cpu_hold=0, start=1, done ← 1, → IDLE.
  - ERROR: rx_ready=0, cpu_hold=1, error=1. load_req → LEN, clearing error.
- Throughput and latency:
  - One word per 3 cycles minimum: LO, HI, WRITE.
  - From the last high byte accepted: im_wren asserts 1 cycle later; start asserts 2 cycles later.
- Boundary rules:
  - Address never wraps. Comparison precedes increment, so a full 2^Im_width image ends at the maximum address.
  - load_req in LEN/LO/HI/WRITE/FINISH is ignored.
  - Bytes offered while rx_ready=0 are not consumed.
  - Reset mid-load returns to IDLE immediately. Memory contents already written are left as is. cpu_hold drops; start is not pulsed.
- im_address and im_data hold their last values outside WRITE. Only im_wren qualifies them.

Decomposition:
- Shared package (processor_pkg) holds:
  - loader state enum: IDLE, LEN, LO, HI, WRITE, FINISH, ERROR
  - localparam for stream byte width (8)
  - reg_width/Im_width defaults (12, 8) shared with the processor top
- One sub-module: loader_word_assembler. It latches low and high bytes, produces the reg_width word, and flags nonzero padding bits.
- The FSM, counters and handshake stay in program_loader.

Test Plan:
- Reset held 2 cycles mid-HI → next cycle all outputs 0 and state IDLE. No im_wren and no start afterwards, even with rx_valid held 1.
- load_req, then stream 0x01,0x34,0x0A,0xCD,0x0B → two writes: addr 0 = 0xA34, addr 1 = 0xBCD.
  - Then start is a 1-cycle pulse, done=1, and cpu_hold falls with start.
- Header 0xFF at Im_width=8, 512 incrementing-pattern bytes → 256 writes, final im_address=0xFF, no wrap, exactly one start pulse.
- Stream 0x00,0x11,0x25 (high nibble 2 nonzero) → ERROR, error=1, cpu_hold=1, no im_wren, rx_ready=0.
  - A later load_req clears error and a valid load completes.
- rx_valid toggled every other cycle, plus load_req asserted during LO → transfers only on valid&&ready, and the load_req is ignored.
- Back-to-back bytes with rx_valid held high → rx_ready low in WRITE; the byte presented during WRITE is accepted in the following LO cycle, not lost.
